// File: rtl/gate_tester.sv
// gate_tester: sequential stimulus driver and checker for a two-input
// combinational gate. It sweeps {a,b} through 00,01,10,11, holds each vector
// for SETTLE cycles, samples the gate output for one cycle and compares it
// against the TRUTH table, repeating the sweep PASSES times. Mismatches are
// counted (saturating) and recorded per vector.
module gate_tester #(
    parameter logic [3:0] TRUTH  = 4'b1000,
    parameter int         SETTLE = 2,
    parameter int         PASSES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dut_c,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [3:0] fail_vec
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Terminal values for the settle and pass counters, sized to the registers.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [7:0] PASSES_L    = 8'(PASSES);

    state_t     r_state;
    logic [1:0] r_idx;
    logic [7:0] r_passCnt;
    logic [3:0] r_settleCnt;
    logic       r_a;
    logic       r_b;
    logic [7:0] r_errCount;
    logic [3:0] r_failVec;

    state_t     w_nextState;
    logic [1:0] w_nextIdx;
    logic [7:0] w_nextPassCnt;
    logic [3:0] w_nextSettleCnt;
    logic       w_nextA;
    logic       w_nextB;
    logic [7:0] w_nextErrCount;
    logic [3:0] w_nextFailVec;
    logic       w_mismatch;
    logic [7:0] w_passInc;

    assign w_mismatch = (dut_c != TRUTH[r_idx]);
    assign w_passInc  = r_passCnt + 8'd1;

    // State register and datapath registers; reset aborts any run immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= 2'd0;
            r_passCnt   <= 8'd0;
            r_settleCnt <= 4'd0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_errCount  <= 8'd0;
            r_failVec   <= 4'd0;
        end else begin
            r_state     <= w_nextState;
            r_idx       <= w_nextIdx;
            r_passCnt   <= w_nextPassCnt;
            r_settleCnt <= w_nextSettleCnt;
            r_a         <= w_nextA;
            r_b         <= w_nextB;
            r_errCount  <= w_nextErrCount;
            r_failVec   <= w_nextFailVec;
        end
    end

    // Next-state logic: start is only honoured from IDLE/DONE, so a start
    // pulse during a run falls through the DRIVE/SAMPLE arms untouched.
    always_comb begin
        w_nextState     = r_state;
        w_nextIdx       = r_idx;
        w_nextPassCnt   = r_passCnt;
        w_nextSettleCnt = r_settleCnt;
        w_nextA         = r_a;
        w_nextB         = r_b;
        w_nextErrCount  = r_errCount;
        w_nextFailVec   = r_failVec;

        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_nextState     = DRIVE;
                    w_nextIdx       = 2'd0;
                    w_nextPassCnt   = 8'd0;
                    w_nextSettleCnt = 4'd0;
                    w_nextA         = 1'b0;
                    w_nextB         = 1'b0;
                    w_nextErrCount  = 8'd0;
                    w_nextFailVec   = 4'd0;
                end
            end
            DRIVE: begin
                w_nextSettleCnt = r_settleCnt + 4'd1;
                if (r_settleCnt == SETTLE_LAST) begin
                    w_nextState = SAMPLE;
                end
            end
            SAMPLE: begin
                if (w_mismatch) begin
                    if (r_errCount != 8'hFF) begin
                        w_nextErrCount = r_errCount + 8'd1;
                    end
                    w_nextFailVec[r_idx] = 1'b1;
                end
                w_nextIdx       = r_idx + 2'd1;
                w_nextSettleCnt = 4'd0;
                if ((r_idx == 2'd3) && (w_passInc == PASSES_L)) begin
                    w_nextPassCnt = w_passInc;
                    w_nextState   = DONE;
                end else begin
                    if (r_idx == 2'd3) begin
                        w_nextPassCnt = w_passInc;
                    end
                    w_nextState = DRIVE;
                    w_nextA     = w_nextIdx[1];
                    w_nextB     = w_nextIdx[0];
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign a         = r_a;
    assign b         = r_b;
    assign busy      = (r_state == DRIVE) || (r_state == SAMPLE);
    assign done      = (r_state == DONE);
    assign pass      = (r_state == DONE) && (r_errCount == 8'd0);
    assign err_count = r_errCount;
    assign fail_vec  = r_failVec;

endmodule

// File: doc/gate_tester.md
# gate_tester

Sequential self-checking driver for a two-input combinational gate under test: it drives both gate inputs through every combination, samples the gate output after a settle interval, and compares it against a parameterised truth table. Its outputs `a` and `b` connect to the gate's inputs, and the gate's output connects back to `dut_c`. It replaces hand-written stimulus for the basic-gate modules. One instance checks one gate; the expected function is selected by parameter.

## Interface
- `TRUTH`, default 4'b1000, is the expected output per input vector, indexed by {a,b]. Bit 0 is a=0,b=0 and bit 3 is a=1,b=1. The default is AND.
- `SETTLE`, default 2, is the number of cycles each vector is held before sampling. The legal range is 1..15.
- `PASSES`, default 1, is the number of full 4-vector sweeps per run. The legal range is 1..255.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `start`  in  1  begins a run; sampled on `clk`.
- `dut_c`  in  1  gate-under-test output.
- `a`  out  1  gate input a; registered.
- `b`  out  1  gate input b; registered.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  high from the end of a run until the next accepted `start`.
- `pass`  out  1  high with `done` when `err_count` = 0.
- `err_count`  out  8  number of mismatches; saturates at 255.
- `fail_vec`  out  4  sticky per-vector mismatch flags; bit i corresponds to vector i.

## Operation
- States:
  - IDLE: entered from reset.
  - DRIVE: the current vector is applied and held.
  - SAMPLE: `dut_c` is compared against the expected value.
  - DONE: the run has finished.
- IDLE/DONE with `start`=1 leads to DRIVE. On that transition:
  - idx=0, {a,b}=00, pass counter=0, settle counter=0.
  - `err_count`, `fail_vec`, `done` and `pass` are cleared.
  - `busy` is set.
- DRIVE: the settle counter increments each cycle. When the counter reaches SETTLE-1, the state moves to SAMPLE.
- SAMPLE, one cycle:
  - If `dut_c` != TRUTH[idx], `err_count` increments, saturating at 255, and `fail_vec[idx]` is set.
  - The state then advances idx and clears the settle counter.
  - If idx was 3, idx wraps to 0 and the pass counter increments.
  - If the pass counter reaches PASSES, the state goes to DONE. Otherwise it returns to DRIVE with the new {a,b}={idx[1],idx[0]}.
- DONE:
  - `busy`=0, `done`=1.
  - `pass`=(`err_count`==0).
  - {a,b} holds its last value (11).
  - The state stays in DONE until `start`.
- `start` while `busy` is ignored and has no effect on the run.
- `a` and `b` change only on the SAMPLE to DRIVE transition or on start. They never change in the cycle that `dut_c` is sampled.
- Error accounting:
  - `err_count` counts every mismatch across all passes.
  - `fail_vec` records which vectors ever failed.
  - Both stay valid in DONE.

## Timing
- Reset values: a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0; state IDLE. Reset takes effect immediately and asynchronously, and mid-run it aborts the run with no completion indication.
- Start: `start` is high at edge E0. `busy`=1 and {a,b}=00 are visible after E0.
- Per vector: SETTLE cycles in DRIVE, then 1 cycle in SAMPLE. `dut_c` is compared at the rising edge that ends the SAMPLE cycle, which is SETTLE+1 edges after the vector was applied.
- Run length: `busy` is high for exactly PASSES*4*(SETTLE+1) cycles. `done` rises at the edge where `busy` falls.
- Final results: `err_count`, `fail_vec` and `pass` are final in the same cycle that `done` first reads 1.
- Restart: `start` in the first DONE cycle is accepted. `done` falls and `busy` rises at the next edge.
- `dut_c` is treated as combinational from `a` and `b`. Its path must settle within SETTLE cycles; no synchroniser is provided.

## Test plan
- AND model, TRUTH=1000, SETTLE=2, PASSES=1, start pulse:
  - {a,b} sequence 00,01,10,11, each held 3 cycles.
  - `busy` high for 12 cycles.
  - done=1, pass=1, err_count=0, fail_vec=0000.
- `dut_c` tied 0 with TRUTH=1000 and PASSES=3 -> err_count=3, fail_vec=1000, pass=0.
- OR model with TRUTH=1000 and PASSES=2 -> err_count=4, fail_vec=0110, pass=0.
- Inverted AND model (NAND) with TRUTH=1000, PASSES=100 -> err_count saturates at 255, fail_vec=1111.
- Control sequencing:
  - Pulse `start` mid-run: no effect; busy duration unchanged.
  - Assert `rst` mid-run: all outputs reset immediately, state IDLE.
  - A new `start` after that gives a clean result.
- After a failing run, restart with a correct DUT -> err_count and fail_vec cleared at start; final pass=1.
